pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
- Supervises the board PLL (50 MHz in; 25/50/100 MHz out) from the raw 50 MHz reference clock.
- Drives the PLL's active-high reset and watches its asynchronous `locked` output.
- Releases the system reset only after lock has been stable for a programmable window. Retries the PLL on lock timeout and restarts it on lock loss.
- Sits directly upstream of the PLL wrapper and of every per-domain reset synchroniser.

Parameters:
- RST_CYCLES, 16: width of the pll_rst pulse in clkin cycles (≥2).
- LOCK_TIMEOUT, 50000: cycles to wait for lock before retrying (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: cycles lock must stay high before sys_rst_n is released.
- CNT_W, 16: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clkin  in  1  50 MHz reference clock (not a PLL output).
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock flag; asynchronous to clkin.
- force_relock  in  1  single-cycle request to restart the PLL.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst_n  out  1  active-low system reset, for downstream synchronisers.
- ready  out  1  high while in S_RUN; equals sys_rst_n.
- state  out  2  current FSM state encoding.
- retry_cnt  out  8  lock timeouts since rst_n; saturates at 255.
- lost_cnt  out  8  lock losses while in S_RUN; saturates at 255.

Behaviour:
- Reset values (rst_n low, async):
  - state = S_RESET, pll_rst = 1, sys_rst_n = 0, ready = 0
  - counter = 0, retry_cnt = 0, lost_cnt = 0, sync flops = 0
- Synchroniser: pll_locked passes through a 2-flop synchroniser to give locked_s. The FSM uses only locked_s.
- Output registers: all outputs are registered and update on the same edge as the state register. No combinational outputs.
- Counter: resets to 0 on every state entry and increments each cycle within a state.
- States (encoding S_RESET=0, S_WAIT=1, S_STABLE=2, S_RUN=3):
  - S_RESET: pll_rst = 1, sys_rst_n = 0. When counter == RST_CYCLES-1, go to S_WAIT. pll_rst is therefore high for exactly RST_CYCLES cycles.
  - S_WAIT: pll_rst = 0, sys_rst_n = 0.
    - locked_s = 1: go to S_STABLE.
    - Else if counter == LOCK_TIMEOUT-1: retry_cnt++ (saturating), go to S_RESET.
    - If locked_s rises on the timeout cycle, locked_s wins: go to S_STABLE, no retry.
  - S_STABLE: sys_rst_n = 0.
    - locked_s = 0: go to S_WAIT. The timeout counter restarts; retry_cnt is not incremented.
    - Else if counter == STABLE_CYCLES-1: go to S_RUN.
  - S_RUN: sys_rst_n = 1, ready = 1. locked_s = 0: lost_cnt++ (saturating), go to S_RESET; sys_rst_n drops on that same edge.
- force_relock:
  - In S_WAIT, S_STABLE or S_RUN: go to S_RESET next edge, with priority over all other transitions. No counter is incremented.
  - In S_RESET: ignored; the pulse is not restarted.
- Latency: from a pll_locked rise (sampled at edge t0) while in S_WAIT:
  - S_STABLE entered at t0+2
  - sys_rst_n high at t0+2+STABLE_CYCLES
- Glitch on pll_locked shorter than one clkin period: may or may not be caught. If caught while in S_RUN, it is treated as a real loss.
- rst_n asserted mid-operation: everything returns to reset values immediately, including the counters.
- Counter width: CNT_W must cover all parameters. Simulation-time assertion if max(...) ≥ 2**CNT_W.

Decomposition:
- Shared package `clk_rst_pkg`:
  - state enum/localparams S_RESET..S_RUN
  - default timing constants (RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) for 50 MHz
- Sub-module `sync2`: generic 2-flop synchroniser with async active-low reset. The downstream per-domain reset bridges reuse it.
- FSM, counter and statistics stay in pll_lock_supervisor.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, CNT_W=8):
- Release rst_n, pll_locked=1 from cycle 10 (t0) → pll_rst high cycles 0-3, low from 4; state=S_STABLE at t0+2; sys_rst_n=1 and ready=1 at t0+10; retry_cnt=0.
- pll_locked held 0 → pll_rst re-pulses every 24 cycles (4 reset + 20 wait); retry_cnt reads 1, 2, 3 after each timeout; sys_rst_n stays 0; after 300 timeouts retry_cnt=255.
- Lock reached, then pll_locked drops for 1 cycle in S_STABLE at counter=5 → back to S_WAIT; sys_rst_n still 0; sys_rst_n=1 exactly 10 cycles after the next rising sample; retry_cnt unchanged.
- In S_RUN, drop pll_locked → sys_rst_n=0 3 cycles after the drop (2 sync + 1 FSM); lost_cnt=1; pll_rst pulses 4 cycles.
- In S_RUN, assert force_relock for one cycle → S_RESET next edge, sys_rst_n=0, lost_cnt=0, retry_cnt=0.
- Assert rst_n=0 during S_STABLE, mid-cycle → all outputs at reset values without waiting for a clock edge; counters cleared.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// -----------------------------------------------------------------------------
// clk_rst_pkg
//
// Shared definitions for the clock/reset infrastructure:
//   - encoding of the PLL lock supervisor FSM states (S_RESET .. S_RUN)
//   - default timing constants for a 50 MHz reference clock
//   - small helpers used by the supervisor (saturating increment, max of three)
//
// No ports; imported with `import clk_rst_pkg::*;`.
// -----------------------------------------------------------------------------
package clk_rst_pkg;

    // FSM state encoding. Kept as plain 2-bit constants so the encoding is
    // visible on the `state` output port and stable across tool versions.
    localparam logic [1:0] S_RESET  = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STABLE = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    // Default timing for a 50 MHz reference.
    localparam int DEFAULT_RST_CYCLES    = 16;     // PLL reset pulse width
    localparam int DEFAULT_LOCK_TIMEOUT  = 50000;  // 1 ms lock timeout
    localparam int DEFAULT_STABLE_CYCLES = 1024;   // lock qualification window
    localparam int DEFAULT_CNT_W         = 16;     // shared counter width

    // Statistics counters stick at all-ones instead of wrapping, so a large
    // value is never mistaken for a small one.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : clk_rst_pkg

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
//
// Generic two-flop synchroniser for signals asynchronous to `clk`. Each bit
// is synchronised independently, so it must only carry signals whose bits
// need no mutual coherence (level flags, reset requests).
//
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous, active-low reset (flops load RST_VAL)
//   d      in   WIDTH-bit asynchronous input
//   q      out  WIDTH-bit synchronised output, two clk edges of latency
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // meta_reg may go metastable; only sync_reg is allowed to fan out.
    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule : sync2

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Runs from the raw reference clock and owns the board PLL's reset. It pulses
// the PLL reset, waits for lock, qualifies lock for a programmable window and
// only then releases the system reset. Lock timeouts retry the PLL, lock loss
// in run restarts it, and force_relock restarts it on request.
//
// Ports:
//   clkin         in   reference clock (not a PLL output)
//   rst_n         in   asynchronous, active-low reset
//   pll_locked    in   PLL lock flag, asynchronous to clkin
//   force_relock  in   single-cycle request to restart the PLL
//   pll_rst       out  active-high PLL reset (registered)
//   sys_rst_n     out  active-low system reset for downstream synchronisers
//   ready         out  high while in S_RUN; identical to sys_rst_n
//   state         out  FSM state encoding (S_RESET=0 .. S_RUN=3)
//   retry_cnt     out  lock timeouts since rst_n, saturating at 255
//   lost_cnt      out  lock losses in S_RUN since rst_n, saturating at 255
// -----------------------------------------------------------------------------
module pll_lock_supervisor
    import clk_rst_pkg::*;
#(
    parameter int RST_CYCLES    = DEFAULT_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEFAULT_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] lost_cnt
);

    // -------------------------------------------------------------------------
    // Parameter sanity checks (elaboration time)
    // -------------------------------------------------------------------------
    localparam int MAX_CYCLES = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    generate
        if (longint'(MAX_CYCLES) >= (longint'(1) << CNT_W)) begin : g_cnt_w_too_small
            $error("pll_lock_supervisor: CNT_W=%0d cannot hold %0d", CNT_W, MAX_CYCLES);
        end
        if (RST_CYCLES < 2) begin : g_rst_cycles_too_small
            $error("pll_lock_supervisor: RST_CYCLES=%0d must be at least 2", RST_CYCLES);
        end
    endgenerate

    // Terminal counter values: the counter starts at 0 on state entry, so a
    // state lasting N cycles leaves when the counter reads N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Lock synchroniser: the FSM must only ever look at locked_s.
    // -------------------------------------------------------------------------
    logic locked_s;

    sync2 #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // -------------------------------------------------------------------------
    // State, counter and statistics registers
    // -------------------------------------------------------------------------
    logic [1:0]       state_reg,     state_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic [7:0]       retry_cnt_reg, retry_cnt_next;
    logic [7:0]       lost_cnt_reg,  lost_cnt_next;
    logic             pll_rst_reg;
    logic             sys_rst_n_reg;
    logic             ready_reg;

    // Next-state logic. force_relock is checked first in every state that
    // honours it, so it wins over lock, timeout and loss handling and never
    // touches the statistics counters. In S_RESET it is ignored so an
    // in-progress PLL reset pulse is never stretched.
    always_comb begin
        state_next     = state_reg;
        retry_cnt_next = retry_cnt_reg;
        lost_cnt_next  = lost_cnt_reg;

        case (state_reg)
            S_RESET: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (force_relock) begin
                    state_next = S_RESET;
                end else if (locked_s) begin
                    // Lock arriving on the timeout cycle still counts as lock.
                    state_next = S_STABLE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next     = S_RESET;
                    retry_cnt_next = sat_inc8(retry_cnt_reg);
                end
            end

            S_STABLE: begin
                if (force_relock) begin
                    state_next = S_RESET;
                end else if (!locked_s) begin
                    // Lock dropped during qualification: keep the PLL running
                    // and give it a fresh timeout window rather than a reset.
                    state_next = S_WAIT;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = S_RUN;
                end
            end

            S_RUN: begin
                if (force_relock) begin
                    state_next = S_RESET;
                end else if (!locked_s) begin
                    state_next    = S_RESET;
                    lost_cnt_next = sat_inc8(lost_cnt_reg);
                end
            end

            default: begin
                state_next = S_RESET;
            end
        endcase
    end

    // The counter restarts on every state change. Within a state it holds at
    // all-ones instead of wrapping; only S_RUN can stay long enough to reach
    // that, and S_RUN never looks at the counter.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Outputs are decoded from state_next and registered, so they change on
    // the same edge as the state register and carry no combinational glitches
    // into the PLL or the downstream reset synchronisers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_RESET;
            cnt_reg       <= '0;
            retry_cnt_reg <= 8'd0;
            lost_cnt_reg  <= 8'd0;
            pll_rst_reg   <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_cnt_reg <= retry_cnt_next;
            lost_cnt_reg  <= lost_cnt_next;
            pll_rst_reg   <= (state_next == S_RESET);
            sys_rst_n_reg <= (state_next == S_RUN);
            ready_reg     <= (state_next == S_RUN);
        end
    end

    assign pll_rst   = pll_rst_reg;
    assign sys_rst_n = sys_rst_n_reg;
    assign ready     = ready_reg;
    assign state     = state_reg;
    assign retry_cnt = retry_cnt_reg;
    assign lost_cnt  = lost_cnt_reg;

endmodule : pll_lock_supervisor
